// File: rtl/vote_controller_if.sv
// rtl/vote_controller_if.sv - vote inputs and result/status outputs of the vote controller
interface vote_controller_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8
);
    localparam int SEL_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

    logic                mode;
    logic [NUM_CAND-1:0] valid_vote;
    logic [SEL_W-1:0]    result_sel;
    logic                vote_ack;
    logic                collision;
    logic                busy;
    logic                overflow;
    logic [CNT_W-1:0]    result_count;
    logic [CNT_W-1:0]    total_votes;

    modport master (
        output mode, valid_vote, result_sel,
        input  vote_ack, collision, busy, overflow, result_count, total_votes
    );

    modport slave (
        input  mode, valid_vote, result_sel,
        output vote_ack, collision, busy, overflow, result_count, total_votes
    );
endinterface

// File: rtl/vote_controller.sv
// rtl/vote_controller.sv - vote arbitration, lockout, saturating tallies and result readout
module vote_controller #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int LOCKOUT  = 5
) (
    input  logic              clock,
    input  logic              reset,
    vote_controller_if.slave  bus
);
    localparam int SEL_W  = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int LOCK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCKOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [SEL_W:0]    NUM_CAND_W = (SEL_W + 1)'(NUM_CAND);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_n;
    logic [CNT_W-1:0]  tally   [NUM_CAND];
    logic [CNT_W-1:0]  tally_n [NUM_CAND];
    logic [CNT_W-1:0]  total, total_n;
    logic [CNT_W-1:0]  result_q, result_n;
    logic              ack_q, ack_n;
    logic              coll_q, coll_n;
    logic              ovf_q, ovf_n;
    logic              one_hot;
    logic              any_vote;

    assign one_hot  = $onehot(bus.valid_vote);
    assign any_vote = |bus.valid_vote;

    always_comb begin
        state_n    = state;
        lock_cnt_n = lock_cnt;
        tally_n    = tally;
        total_n    = total;
        result_n   = '0;
        ack_n      = 1'b0;
        coll_n     = 1'b0;
        ovf_n      = ovf_q;
        case (state)
            IDLE: begin
                // Mode is checked first so a press coinciding with the switch is dropped.
                if (bus.mode) begin
                    state_n = RESULT;
                end else if (one_hot) begin
                    ack_n      = 1'b1;
                    state_n    = LOCK;
                    lock_cnt_n = LOCK_LOAD;
                    for (int i = 0; i < NUM_CAND; i++) begin
                        if (bus.valid_vote[i]) begin
                            if (tally[i] == CNT_MAX) ovf_n = 1'b1;
                            else tally_n[i] = tally[i] + CNT_W'(1);
                        end
                    end
                    if (total == CNT_MAX) ovf_n = 1'b1;
                    else total_n = total + CNT_W'(1);
                end else if (any_vote) begin
                    coll_n     = 1'b1;
                    state_n    = LOCK;
                    lock_cnt_n = LOCK_LOAD;
                end
            end
            LOCK: begin
                if (lock_cnt == '0) state_n = IDLE;
                else lock_cnt_n = lock_cnt - LOCK_W'(1);
            end
            RESULT: begin
                if (!bus.mode) state_n = IDLE;
                else if ({1'b0, bus.result_sel} < NUM_CAND_W) result_n = tally[bus.result_sel];
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
            total    <= '0;
            result_q <= '0;
            ack_q    <= 1'b0;
            coll_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
        end else begin
            state    <= state_n;
            lock_cnt <= lock_cnt_n;
            total    <= total_n;
            result_q <= result_n;
            ack_q    <= ack_n;
            coll_q   <= coll_n;
            ovf_q    <= ovf_n;
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= tally_n[i];
        end
    end

    assign bus.vote_ack     = ack_q;
    assign bus.collision    = coll_q;
    assign bus.busy         = (state == LOCK);
    assign bus.overflow     = ovf_q;
    assign bus.result_count = result_q;
    assign bus.total_votes  = total;
endmodule

// File: tb/tb_vote_controller.sv
// tb/tb_vote_controller.sv - randomized and directed checks of vote_controller against a behavioural model
module tb_vote_controller;
    localparam int NC  = 4;
    localparam int CW  = 3;
    localparam int LO  = 5;
    localparam int SW  = 2;
    localparam int OW  = 4 + 2 * CW;
    localparam int MAXV = (1 << CW) - 1;

    logic clock;
    logic reset;
    int   passed;
    int   total;

    vote_controller_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();

    vote_controller #(.NUM_CAND(NC), .CNT_W(CW), .LOCKOUT(LO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: counts of votes, a remaining-lockout budget and a display flag.
    int   m_tally [NC];
    int   m_total;
    bit   m_ovf;
    int   busy_left;
    bit   in_result;
    bit   e_ack;
    bit   e_coll;
    int   e_rc;

    task automatic model_edge(input logic rst, input logic m, input logic [NC-1:0] vv,
                              input logic [SW-1:0] sel);
        e_ack  = 1'b0;
        e_coll = 1'b0;
        if (rst) begin
            foreach (m_tally[i]) m_tally[i] = 0;
            m_total   = 0;
            m_ovf     = 1'b0;
            busy_left = 0;
            in_result = 1'b0;
            e_rc      = 0;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            e_rc      = 0;
        end else if (in_result) begin
            if (!m) begin
                in_result = 1'b0;
                e_rc      = 0;
            end else begin
                e_rc = (int'(sel) < NC) ? m_tally[sel] : 0;
            end
        end else if (m) begin
            in_result = 1'b1;
            e_rc      = 0;
        end else if ($countones(vv) == 1) begin
            for (int i = 0; i < NC; i++) begin
                if (vv[i]) begin
                    if (m_tally[i] == MAXV) m_ovf = 1'b1;
                    else m_tally[i] = m_tally[i] + 1;
                end
            end
            if (m_total == MAXV) m_ovf = 1'b1;
            else m_total = m_total + 1;
            e_ack     = 1'b1;
            busy_left = LO;
        end else if (vv != '0) begin
            e_coll    = 1'b1;
            busy_left = LO;
        end
    endtask

    task automatic drive(input logic rst, input logic m, input logic [NC-1:0] vv,
                         input logic [SW-1:0] sel);
        @(negedge clock);
        reset          = rst;
        bus.mode       = m;
        bus.valid_vote = vv;
        bus.result_sel = sel;
        @(posedge clock);
        model_edge(rst, m, vv, sel);
        #1;
    endtask

    function automatic logic [OW-1:0] obs();
        return {bus.vote_ack, bus.collision, bus.busy, bus.overflow, bus.result_count, bus.total_votes};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {e_ack, e_coll, (busy_left > 0), m_ovf, CW'(e_rc), CW'(m_total)};
    endfunction

    task automatic test_reset();
        drive(1'b1, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        total++;
        if (obs() !== '0) $display("FAIL reset_state got=%h want=0", obs());
        else passed++;
    endtask

    task automatic test_single_vote();
        drive(1'b0, 1'b0, 4'b0001, '0);
        total++;
        if (bus.vote_ack !== 1'b1 || bus.total_votes !== CW'(1) || bus.busy !== 1'b1)
            $display("FAIL single_vote_ack ack=%b total=%0d busy=%b want 1/1/1",
                     bus.vote_ack, bus.total_votes, bus.busy);
        else passed++;
        for (int c = 0; c < LO; c++) begin
            drive(1'b0, 1'b0, '0, '0);
            total++;
            if (obs() !== expv()) $display("FAIL single_vote_lock c=%0d got=%h want=%h", c, obs(), expv());
            else passed++;
        end
        total++;
        if (bus.busy !== 1'b0) $display("FAIL single_vote_busy_end got=%b want=0", bus.busy);
        else passed++;
    endtask

    task automatic test_collision();
        drive(1'b0, 1'b0, 4'b0110, '0);
        total++;
        if (bus.collision !== 1'b1 || bus.vote_ack !== 1'b0 || bus.total_votes !== CW'(1))
            $display("FAIL collision got coll=%b ack=%b total=%0d want 1/0/1",
                     bus.collision, bus.vote_ack, bus.total_votes);
        else passed++;
        for (int c = 0; c < LO; c++) begin
            drive(1'b0, 1'b0, '0, '0);
            total++;
            if (obs() !== expv()) $display("FAIL collision_lock c=%0d got=%h want=%h", c, obs(), expv());
            else passed++;
        end
    endtask

    task automatic test_lockout();
        drive(1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b0, 4'b0100, '0);
        for (int c = 0; c < LO; c++) begin
            drive(1'b0, 1'b0, 4'b1000, '0);
            total++;
            if (bus.vote_ack !== 1'b0 || obs() !== expv())
                $display("FAIL lockout_ignore c=%0d got=%h want=%h", c, obs(), expv());
            else passed++;
        end
        drive(1'b0, 1'b0, 4'b1000, '0);
        total++;
        if (bus.vote_ack !== 1'b1 || bus.total_votes !== CW'(2))
            $display("FAIL lockout_after ack=%b total=%0d want 1/2", bus.vote_ack, bus.total_votes);
        else passed++;
        for (int c = 0; c < LO; c++) drive(1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b1, '0, 2'd3);
        drive(1'b0, 1'b1, '0, 2'd3);
        total++;
        if (bus.result_count !== CW'(1)) $display("FAIL lockout_tally3 got=%0d want=1", bus.result_count);
        else passed++;
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b0, '0, '0);
        for (int v = 1; v <= 8; v++) begin
            drive(1'b0, 1'b0, 4'b0010, '0);
            total++;
            if (bus.vote_ack !== 1'b1 || bus.overflow !== (v == 8) || bus.total_votes !== CW'(v > MAXV ? MAXV : v))
                $display("FAIL saturation v=%0d ack=%b ovf=%b total=%0d", v, bus.vote_ack, bus.overflow, bus.total_votes);
            else passed++;
            for (int c = 0; c < LO; c++) drive(1'b0, 1'b0, '0, '0);
        end
        drive(1'b0, 1'b1, '0, 2'd1);
        drive(1'b0, 1'b1, '0, 2'd1);
        total++;
        if (bus.result_count !== CW'(MAXV) || bus.overflow !== 1'b1)
            $display("FAIL saturation_tally1 got=%0d ovf=%b want=%0d/1", bus.result_count, bus.overflow, MAXV);
        else passed++;
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 4'b0001, '0);
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 4'b0010, '0);
        total++;
        if (bus.busy !== 1'b0 || bus.total_votes !== '0 || bus.overflow !== 1'b0 || bus.vote_ack !== 1'b0)
            $display("FAIL reset_mid busy=%b total=%0d ovf=%b ack=%b want all 0",
                     bus.busy, bus.total_votes, bus.overflow, bus.vote_ack);
        else passed++;
        drive(1'b0, 1'b1, '0, 2'd1);
        for (int s = 0; s < NC; s++) begin
            drive(1'b0, 1'b1, '0, SW'(s));
            total++;
            if (bus.result_count !== '0) $display("FAIL reset_mid_tally s=%0d got=%0d want=0", s, bus.result_count);
            else passed++;
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_result();
        logic [NC-1:0] votes [6];
        int            want [NC];
        votes = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b1000};
        want  = '{3, 1, 0, 2};
        drive(1'b1, 1'b0, '0, '0);
        foreach (votes[k]) begin
            drive(1'b0, 1'b0, votes[k], '0);
            for (int c = 0; c < LO; c++) drive(1'b0, 1'b0, '0, '0);
        end
        drive(1'b0, 1'b1, 4'b0001, '0);
        total++;
        if (bus.result_count !== '0 || bus.vote_ack !== 1'b0)
            $display("FAIL result_enter rc=%0d ack=%b want 0/0", bus.result_count, bus.vote_ack);
        else passed++;
        for (int s = 0; s < NC; s++) begin
            drive(1'b0, 1'b1, '0, SW'(s));
            total++;
            if (bus.result_count !== CW'(want[s]))
                $display("FAIL result_sel s=%0d got=%0d want=%0d", s, bus.result_count, want[s]);
            else passed++;
        end
        drive(1'b0, 1'b1, 4'b1000, 2'd3);
        total++;
        if (bus.vote_ack !== 1'b0 || bus.collision !== 1'b0 || bus.total_votes !== CW'(6) || bus.result_count !== CW'(2))
            $display("FAIL result_ignore_vote got=%h want=%h", obs(), expv());
        else passed++;
        drive(1'b0, 1'b0, '0, 2'd0);
        total++;
        if (bus.result_count !== '0) $display("FAIL result_exit got=%0d want=0", bus.result_count);
        else passed++;
    endtask

    task automatic test_random();
        logic          m;
        logic          rst;
        logic [NC-1:0] vv;
        m = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) m = ~m;
            vv = ($urandom_range(0, 9) < 6) ? '0 : NC'($urandom);
            drive(rst, m, vv, SW'($urandom));
            total++;
            if (obs() !== expv()) $display("FAIL random c=%0d got=%h want=%h", c, obs(), expv());
            else passed++;
        end
    endtask

    initial begin
        passed         = 0;
        total          = 0;
        reset          = 1'b1;
        bus.mode       = 1'b0;
        bus.valid_vote = '0;
        bus.result_sel = '0;
        test_reset();
        test_single_vote();
        test_collision();
        test_lockout();
        test_saturation();
        test_reset_mid();
        test_result();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
